// File: rtl/lr5_shift_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lr5_shift_ctrl
//  Purpose  : Sequencing controller for the LR5 64-bit nibble-rotate register.
//             Conditions the raw push-buttons, arbitrates manual requests,
//             auto-rotate ticks and homing. It emits mutually exclusive
//             one-cycle SHIFT_R / SHIFT_L pulses and tracks the net rotation
//             offset (POS, modulo 16).
//  Ports    : CLK, RST       clock, asynchronous active-high reset
//             BTN_R/L/HOME   raw asynchronous push-buttons
//             AUTO_EN/DIR    auto-rotate enable and direction (1 = left)
//             SHIFT_R/L      registered one-cycle shift pulses
//             POS            registered net rotation offset
//             BUSY           high in the cycles that carry homing pulses
//  Revision : 1.0  initial release
// ============================================================================
module lr5_shift_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int AUTO_DIV   = 25_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_R,
    input  logic       BTN_L,
    input  logic       BTN_HOME,
    input  logic       AUTO_EN,
    input  logic       AUTO_DIR,
    output logic       SHIFT_R,
    output logic       SHIFT_L,
    output logic [3:0] POS,
    output logic       BUSY
);

    localparam int                  DEB_W     = $clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0]    DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam int                  AUTO_W    = $clog2(AUTO_DIV);
    localparam logic [AUTO_W-1:0]   AUTO_LAST = AUTO_W'(AUTO_DIV - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_HOMING = 1'b1;

    // Bit order: 0 = right, 1 = left, 2 = home
    logic [2:0] btn_raw;
    logic [2:0] req;

    assign btn_raw = {BTN_HOME, BTN_L, BTN_R};

    // ------------------------------------------------------------------
    // Button conditioning: 2-FF synchronizer, debounce, rising-edge detect
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             deb_q;
            logic             deb_prev_q;
            logic [DEB_W-1:0] cnt_q;

            // cnt_q counts consecutive synchronized samples that disagree with
            // the accepted level; the DEB_CYCLES-th such sample flips it.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    sync1_q    <= 1'b0;
                    sync2_q    <= 1'b0;
                    deb_q      <= 1'b0;
                    deb_prev_q <= 1'b0;
                    cnt_q      <= '0;
                end else begin
                    sync1_q    <= btn_raw[gi];
                    sync2_q    <= sync1_q;
                    deb_prev_q <= deb_q;
                    if (sync2_q == deb_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        deb_q <= sync2_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + DEB_W'(1);
                    end
                end
            end

            assign req[gi] = deb_q & ~deb_prev_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic [0:0]        state_q, state_d;
    logic              dir_l_q, dir_l_d;
    logic [2:0]        rem_q, rem_d;
    logic              shift_r_q, shift_r_d;
    logic              shift_l_q, shift_l_d;
    logic              busy_q, busy_d;
    logic [3:0]        pos_q;
    logic [3:0]        pos_eff;
    logic [3:0]        home_len_m1;
    logic [AUTO_W-1:0] auto_cnt_q;
    logic              idle;
    logic              tick;
    logic              home_left;
    logic              start_home;

    // The pulse currently on SHIFT_* is applied to the register at the coming
    // edge, so decisions taken at that edge must see the offset including it.
    always_comb begin
        pos_eff = pos_q;
        if (shift_r_q) begin
            pos_eff = pos_q + 4'd1;
        end else if (shift_l_q) begin
            pos_eff = pos_q - 4'd1;
        end
    end

    assign idle        = (state_q == ST_IDLE);
    assign tick        = AUTO_EN & idle & (auto_cnt_q == AUTO_LAST);
    assign home_left   = (pos_eff <= 4'd8);
    // Pulses still to go after the first one: pos-1 going left, 15-pos right.
    assign home_len_m1 = home_left ? (pos_eff - 4'd1) : ~pos_eff;
    assign start_home  = idle & req[2] & (pos_eff != 4'd0);

    // ------------------------------------------------------------------
    // Auto-rotate divider; frozen while homing, cleared when disabled
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            auto_cnt_q <= '0;
        end else if (!AUTO_EN) begin
            auto_cnt_q <= '0;
        end else if (idle) begin
            auto_cnt_q <= (auto_cnt_q == AUTO_LAST) ? '0 : auto_cnt_q + AUTO_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            dir_l_q   <= 1'b0;
            rem_q     <= '0;
            shift_r_q <= 1'b0;
            shift_l_q <= 1'b0;
            busy_q    <= 1'b0;
            pos_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            dir_l_q   <= dir_l_d;
            rem_q     <= rem_d;
            shift_r_q <= shift_r_d;
            shift_l_q <= shift_l_d;
            busy_q    <= busy_d;
            pos_q     <= pos_eff;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dir_l_d = dir_l_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start_home) begin
                    state_d = ST_HOMING;
                    dir_l_d = home_left;
                    rem_d   = home_len_m1[2:0];
                end
            end
            ST_HOMING: begin
                if (rem_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        shift_r_d = 1'b0;
        shift_l_d = 1'b0;
        busy_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_home) begin
                    // First homing pulse leaves in the same cycle as entry.
                    busy_d    = 1'b1;
                    shift_l_d = home_left;
                    shift_r_d = ~home_left;
                end else if (req[0] | req[1]) begin
                    // A simultaneous R+L cancels itself and still eats the tick.
                    shift_r_d = req[0] & ~req[1];
                    shift_l_d = req[1] & ~req[0];
                end else if (tick) begin
                    shift_l_d = AUTO_DIR;
                    shift_r_d = ~AUTO_DIR;
                end
            end
            ST_HOMING: begin
                if (rem_q != 3'd0) begin
                    busy_d    = 1'b1;
                    shift_l_d = dir_l_q;
                    shift_r_d = ~dir_l_q;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign SHIFT_R = shift_r_q;
    assign SHIFT_L = shift_l_q;
    assign POS     = pos_q;
    assign BUSY    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lr5_shift_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lr5_shift_ctrl
//  Purpose  : Self-checking bench for lr5_shift_ctrl (DEB_CYCLES=4, AUTO_DIV=8)
//  Revision : 1.0  initial release
// ============================================================================
module tb_lr5_shift_ctrl;

    localparam int DEB   = 4;
    localparam int DIV   = 8;
    localparam int LAT   = DEB + 3;
    localparam int TOTAL = 30;

    logic       CLK      = 1'b0;
    logic       RST      = 1'b1;
    logic       BTN_R    = 1'b0;
    logic       BTN_L    = 1'b0;
    logic       BTN_HOME = 1'b0;
    logic       AUTO_EN  = 1'b0;
    logic       AUTO_DIR = 1'b0;
    logic       SHIFT_R;
    logic       SHIFT_L;
    logic [3:0] POS;
    logic       BUSY;

    always #5 CLK = ~CLK;

    lr5_shift_ctrl #(.DEB_CYCLES(DEB), .AUTO_DIV(DIV)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_R    (BTN_R),
        .BTN_L    (BTN_L),
        .BTN_HOME (BTN_HOME),
        .AUTO_EN  (AUTO_EN),
        .AUTO_DIR (AUTO_DIR),
        .SHIFT_R  (SHIFT_R),
        .SHIFT_L  (SHIFT_L),
        .POS      (POS),
        .BUSY     (BUSY)
    );

    int errors = 0;
    int checks = 0;
    int cyc, n_r, n_l, n_busy, first_any, first_r, first_l, last_r, both;
    int pos_m;

    typedef struct {
        logic       r;
        logic       l;
        logic       h;
        int         hold;
        int         exp_r;
        int         exp_l;
        int         exp_busy;
        int         exp_first;
        logic [3:0] exp_pos;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; n_r = 0; n_l = 0; n_busy = 0; both = 0;
        first_any = -1; first_r = -1; first_l = -1; last_r = -1;
    endtask

    // One clock; outputs observed 1 ns after the active edge.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (SHIFT_R === 1'b1) begin
            n_r++;
            if (first_r < 0) first_r = cyc;
            last_r = cyc;
        end
        if (SHIFT_L === 1'b1) begin
            n_l++;
            if (first_l < 0) first_l = cyc;
        end
        if ((SHIFT_R === 1'b1 || SHIFT_L === 1'b1) && first_any < 0) first_any = cyc;
        if (BUSY === 1'b1) n_busy++;
        if (SHIFT_R === 1'b1 && SHIFT_L === 1'b1) both++;
    endtask

    task automatic press(input logic r, input logic l, input logic h, input int hold, input int total);
        clr();
        BTN_R = r; BTN_L = l; BTN_HOME = h;
        repeat (hold) step();
        BTN_R = 1'b0; BTN_L = 1'b0; BTN_HOME = 1'b0;
        while (cyc < total) step();
    endtask

    task automatic expect_op(input string tag, input int er, input int el, input int eb,
                             input int ef, input int ep);
        chk({tag, " n_shift_r"}, n_r, er);
        chk({tag, " n_shift_l"}, n_l, el);
        chk({tag, " n_busy"}, n_busy, eb);
        chk({tag, " first_pulse"}, first_any, ef);
        chk({tag, " pos"}, {28'd0, POS}, ep[31:0] & 32'hF);
        chk({tag, " both_high"}, both, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, hold, k, er, el, eb, ef;
        logic d;

        // row: r l h hold | n_r n_l n_busy first pos
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 20, 1, 0, 0, LAT,  4'd1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0,  3, 0, 0, 0, -1,   4'd1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0,  8, 0, 0, 0, -1,   4'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0,  6, 0, 1, 0, LAT,  4'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0,  6, 0, 1, 0, LAT,  4'd15};
        tbl[5]  = '{1'b0, 1'b1, 1'b0,  6, 0, 1, 0, LAT,  4'd14};
        tbl[6]  = '{1'b0, 1'b1, 1'b0,  6, 0, 1, 0, LAT,  4'd13};
        tbl[7]  = '{1'b0, 1'b0, 1'b1,  6, 3, 0, 3, LAT,  4'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1,  6, 0, 0, 0, -1,   4'd0};
        for (int i = 0; i < 8; i++) tbl[9 + i] = '{1'b1, 1'b0, 1'b0, 5, 1, 0, 0, LAT, 4'(i + 1)};
        tbl[17] = '{1'b0, 1'b0, 1'b1,  6, 0, 8, 8, LAT,  4'd0};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("reset shift_r", {31'd0, SHIFT_R}, 0);
        chk("reset shift_l", {31'd0, SHIFT_L}, 0);
        chk("reset pos", {28'd0, POS}, 0);
        chk("reset busy", {31'd0, BUSY}, 0);
        RST = 1'b0;
        step();

        // Table of button vectors
        for (int i = 0; i < 18; i++) begin
            press(tbl[i].r, tbl[i].l, tbl[i].h, tbl[i].hold, TOTAL);
            expect_op($sformatf("vec%0d", i), tbl[i].exp_r, tbl[i].exp_l,
                      tbl[i].exp_busy, tbl[i].exp_first, int'(tbl[i].exp_pos));
        end

        // Homing right from 13 with a left press landing mid-homing
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, 6, TOTAL);
        chk("pre-home pos", {28'd0, POS}, 13);
        clr();
        BTN_HOME = 1'b1;
        step();
        BTN_L = 1'b1;
        repeat (6) step();
        BTN_HOME = 1'b0; BTN_L = 1'b0;
        while (cyc < TOTAL) step();
        expect_op("home_drop_l", 3, 0, 3, LAT, 0);

        // Auto mode, right, 40 cycles
        clr();
        AUTO_DIR = 1'b0; AUTO_EN = 1'b1;
        repeat (40) step();
        chk("auto n_r", n_r, 5);
        chk("auto first", first_r, DIV);
        chk("auto last", last_r, 5 * DIV);
        step();
        AUTO_EN = 1'b0;
        repeat (2) step();
        chk("auto pos", {28'd0, POS}, 5);
        chk("auto n_r after stop", n_r, 5);

        // Manual left colliding with an auto tick
        clr();
        AUTO_DIR = 1'b0; AUTO_EN = 1'b1;
        step();
        BTN_L = 1'b1;
        while (cyc < 7) step();
        BTN_L = 1'b0;
        while (cyc < 20) step();
        AUTO_EN = 1'b0;
        repeat (2) step();
        chk("collide n_l", n_l, 1);
        chk("collide first_l", first_l, DIV);
        chk("collide n_r", n_r, 1);
        chk("collide first_r", first_r, 2 * DIV);
        chk("collide both", both, 0);
        chk("collide pos", {28'd0, POS}, 5);

        // Reset mid-homing from 12
        press(1'b0, 1'b0, 1'b1, 6, TOTAL);
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0, 6, TOTAL);
        chk("pre-reset pos", {28'd0, POS}, 12);
        clr();
        BTN_HOME = 1'b1;
        while (n_r < 2 && cyc < 40) step();
        chk("mid-home pulses", n_r, 2);
        chk("mid-home busy", {31'd0, BUSY}, 1);
        #2 RST = 1'b1;
        #1;
        chk("async rst shift_r", {31'd0, SHIFT_R}, 0);
        chk("async rst pos", {28'd0, POS}, 0);
        chk("async rst busy", {31'd0, BUSY}, 0);
        BTN_HOME = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        clr();
        repeat (TOTAL) step();
        expect_op("after_rst", 0, 0, 0, -1, 0);

        // Randomized operations against an offset model
        pos_m = 0;
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 5);
            hold = $urandom_range(4, 10);
            er = 0; el = 0; eb = 0; ef = -1;
            case (op)
                0: begin
                    press(1'b1, 1'b0, 1'b0, hold, TOTAL);
                    er = 1; ef = LAT; pos_m = (pos_m + 1) % 16;
                end
                1: begin
                    press(1'b0, 1'b1, 1'b0, hold, TOTAL);
                    el = 1; ef = LAT; pos_m = (pos_m + 15) % 16;
                end
                2: begin
                    press(1'b0, 1'b0, 1'b1, hold, TOTAL);
                    if (pos_m != 0) begin
                        if (pos_m <= 8) el = pos_m; else er = 16 - pos_m;
                        eb = el + er; ef = LAT; pos_m = 0;
                    end
                end
                3: press(1'b1, 1'b1, 1'b0, hold, TOTAL);
                4: begin
                    k = $urandom_range(0, 2);
                    press(k == 0, k == 1, k == 2, $urandom_range(1, DEB - 1), TOTAL);
                end
                default: begin
                    k = $urandom_range(DIV, 5 * DIV);
                    d = 1'($urandom_range(0, 1));
                    clr();
                    AUTO_DIR = d; AUTO_EN = 1'b1;
                    repeat (k) step();
                    AUTO_EN = 1'b0;
                    repeat (2) step();
                    if (d) el = k / DIV; else er = k / DIV;
                    ef = DIV;
                    pos_m = d ? (pos_m + 16 * 4 - k / DIV) % 16 : (pos_m + k / DIV) % 16;
                end
            endcase
            expect_op($sformatf("rnd%0d op%0d", i, op), er, el, eb, ef, pos_m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
